// File: rtl/rf_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rf_pkg: shared constants, address type and bus-slicing helpers.       |
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
package rf_pkg;

  localparam int unsigned XLEN_DEF = 32;
  localparam int unsigned NREG_DEF = 32;
  localparam int unsigned AW_DEF   = $clog2(NREG_DEF);

  typedef logic [AW_DEF-1:0] reg_addr_t;

  // Base bit of port k inside a flattened address / data bus.
  function automatic int unsigned addr_slice(input int unsigned port, input int unsigned aw);
    return port * aw;
  endfunction

  function automatic int unsigned data_slice(input int unsigned port, input int unsigned xlen);
    return port * xlen;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rf_scoreboard.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rf_scoreboard: per-register busy bits with flush/issue/wb priority.   |
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
module rf_scoreboard #(
  parameter int unsigned NREG = 32,
  parameter int unsigned AW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            iss_en,
  input  logic [AW-1:0]   iss_addr,
  input  logic            wb_en,
  input  logic [AW-1:0]   wb_addr,
  input  logic            flush,
  output logic [NREG-1:0] busy_vec
);

  logic [NREG-1:0] r_busy;

  // The set is applied after the clear so a same-register issue wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= '0;
    end else if (flush) begin
      r_busy <= '0;
    end else begin
      if (wb_en && (wb_addr != '0))
        r_busy[wb_addr] <= 1'b0;
      if (iss_en && (iss_addr != '0))
        r_busy[iss_addr] <= 1'b1;
    end
  end

  assign busy_vec = r_busy;

endmodule
`default_nettype wire

// File: rtl/rf_bypass_sb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rf_bypass_sb: N-read-port register file with wb bypass and scoreboard.|
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
module rf_bypass_sb
  import rf_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF,
  parameter int unsigned NREG = NREG_DEF,
  parameter int unsigned NRD  = 2,
  parameter int unsigned AW   = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NRD*AW-1:0]   rs_addr,
  output logic [NRD*XLEN-1:0] rs_data,
  output logic [NRD-1:0]      rs_busy,
  input  logic                wb_en,
  input  logic [AW-1:0]       wb_addr,
  input  logic [XLEN-1:0]     wb_data,
  input  logic                iss_en,
  input  logic [AW-1:0]       iss_addr,
  input  logic                flush,
  output logic [NREG-1:0]     busy_vec
);

  logic [XLEN-1:0] r_regfile [NREG];
  logic            w_wr;

  assign w_wr = wb_en && (wb_addr != '0);

  // Entry 0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++)
        r_regfile[i] <= '0;
    end else if (w_wr) begin
      r_regfile[wb_addr] <= wb_data;
    end
  end

  rf_scoreboard #(
    .NREG (NREG),
    .AW   (AW)
  ) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .wb_en    (wb_en),
    .wb_addr  (wb_addr),
    .flush    (flush),
    .busy_vec (busy_vec)
  );

  for (genvar k = 0; k < NRD; k++) begin : g_rd_port
    localparam int unsigned c_ABASE = addr_slice(k, AW);
    localparam int unsigned c_DBASE = data_slice(k, XLEN);

    logic [AW-1:0] w_addr;
    logic          w_byp;

    assign w_addr = rs_addr[c_ABASE +: AW];
    assign w_byp  = w_wr && (wb_addr == w_addr);

    assign rs_data[c_DBASE +: XLEN] = w_byp ? wb_data : r_regfile[w_addr];
    assign rs_busy[k]               = w_byp ? 1'b0    : busy_vec[w_addr];
  end

endmodule
`default_nettype wire

// File: doc/rf_bypass_sb.md
# rf_bypass_sb

Parametrised integer register file for the RISC-V core, the successor to the fixed 32×32, 2-read/1-write file. It adds a configurable number of read ports, same-cycle write-to-read bypass, and a per-register scoreboard that marks registers with an outstanding writeback. It sits between decode/issue, which reads operands, sets busy bits and checks hazards, and the writeback stage, which writes results and clears busy bits.

## Interface
Parameters:
- XLEN, 32: data width in bits.
- NREG, 32: number of architectural registers; must be a power of 2 and ≥ 2.
- NRD, 2: number of read ports.
- AW, $clog2(NREG): address width (derived; not overridden).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- rs_addr  in  NRD*AW  read addresses; port k uses bits [k*AW +: AW].
- rs_data  out  NRD*XLEN  read data; port k uses bits [k*XLEN +: XLEN].
- rs_busy  out  NRD  per-port hazard flag: the operand is not yet valid.
- wb_en  in  1  writeback strobe.
- wb_addr  in  AW  writeback destination.
- wb_data  in  XLEN  writeback value.
- iss_en  in  1  issue strobe: an instruction with destination iss_addr is dispatched.
- iss_addr  in  AW  destination of the issued instruction.
- flush  in  1  synchronous clear of all busy bits (pipeline flush).
- busy_vec  out  NREG  scoreboard state, registered, for debug.

## Operation
- State consists of regfile[NREG] (XLEN bits each) and busy[NREG] (1 bit each).
- Register 0 is hardwired to zero:
  - Writes to address 0 are dropped.
  - busy[0] is never set.
  - Reads of address 0 return 0 with rs_busy = 0.
- Write: when wb_en is high and wb_addr ≠ 0, regfile[wb_addr] ← wb_data on the clock edge.
- Read port k is combinational:
  - If wb_en is high, wb_addr == rs_addr[k] and the address is ≠ 0, then rs_data[k] = wb_data (bypass) and rs_busy[k] = 0.
  - Otherwise rs_data[k] = regfile[rs_addr[k]] and rs_busy[k] = busy[rs_addr[k]].
- Scoreboard update per edge, in priority order:
  1. flush clears every busy bit. A simultaneous iss_en is ignored and wb_en is still honoured.
  2. If iss_en is high and iss_addr ≠ 0, busy[iss_addr] ← 1.
  3. If wb_en is high and wb_addr ≠ 0, busy[wb_addr] ← 0, unless the same register is being set by iss_en in this cycle; a new producer wins, so the bit stays 1.
- Issue and writeback to different registers in the same cycle both take effect.
- A writeback to a register that is not busy is legal: the data is written and the bit stays 0.
- Reads are never blocked. rs_busy is advisory to issue logic.

## Timing
- Read latency is 0 cycles (combinational), including the bypass path.
- Write latency is 1 cycle: a read of wb_addr in the cycle after the write returns the new value from the array.
- busy_vec and rs_busy reflect a set one cycle after iss_en.
- A busy clear is visible on rs_busy in the same cycle as wb_en through the bypass, and in busy_vec on the next cycle.
- Reset, asserted asynchronously at any time including mid-write:
  - All regfile entries are 0 and all busy bits are 0 immediately.
  - As a result, rs_data = 0, rs_busy = 0 and busy_vec = 0 while rst_n is low, except when a live bypass drives rs_data.
  - The first edge after rst_n deasserts may write.

## Structure
- Shared package rf_pkg:
  - Default XLEN/NREG constants.
  - Register-address typedef.
  - Packing/unpacking helpers (addr_slice, data_slice) for the flattened port buses.
- Sub-module rf_scoreboard: holds busy[NREG], applies the flush/issue/writeback priority and produces busy_vec.
- The top level holds the data array, the bypass muxes and a generate loop over NRD read ports.

## Test plan
- Reset, then read x5 and x31 → rs_data = 0, rs_busy = 0, busy_vec = 0.
- wb_en with addr 7 and data 0xDEADBEEF, while port 0 reads x7 in the same cycle → rs_data[0] = 0xDEADBEEF via bypass. The next cycle reads 0xDEADBEEF from the array.
- Write 0x1234 to x0 while iss_en targets x0 → reading x0 gives 0, busy_vec[0] stays 0.
- iss_en for x3, then read x3 → rs_busy = 1 next cycle. wb_en for x3 with data 0x55 → same-cycle rs_busy = 0 and rs_data = 0x55, busy_vec[3] = 0 the next cycle.
- iss_en and wb_en to x9 in the same cycle → busy_vec[9] = 1 and regfile[9] updated. flush with iss_en to x4 → busy_vec = 0.
- NRD = 4, XLEN = 64: four ports read x1..x4 after writing 64'h0123_4567_89AB_CDEF+i → each port returns its value. Assert rst_n low mid-sequence → all reads 0 immediately.
